// File: rtl/hough_pkg.sv
// Shared constants and reader state encoding for the Hough line detector.
// The voting FSM and the peak reader both use MAX_RHO and the bin count
// from here, so rho <-> address mapping cannot drift between them.
package hough_pkg;

  localparam int ADDR_W    = 11;    // accumulator address width
  localparam int COUNT_W   = 16;    // vote counter width per bin
  localparam int RHO_BINS  = 1600;  // bins scanned: addresses 0..RHO_BINS-1
  localparam int MAX_RHO   = 800;   // rho = address - MAX_RHO
  localparam int THRESHOLD = 100;   // minimum votes for a candidate

  // Peak reader states, one-hot.
  typedef enum logic [5:0] {
    RD_IDLE    = 6'b000001,
    RD_ISSUE   = 6'b000010,
    RD_CAPTURE = 6'b000100,
    RD_EVAL    = 6'b001000,
    RD_EMIT    = 6'b010000,
    RD_FINISH  = 6'b100000
  } rd_state_t;

endpackage

// File: rtl/hough_peak_reader_if.sv
// Bus bundle between the peak reader, the rho accumulator RAM and the
// candidate consumer.
//
// Candidate stream handshake: a candidate transfers on every rising clock
// edge where peak_valid && peak_ready. Once peak_valid is raised, it and
// peak_rho/peak_votes stay unchanged until that transfer edge; peak_ready
// may change freely and is never required before peak_valid.
//
// RAM side: mem_read_data returns the word at mem_address one cycle after
// the address is presented (registered read). mem_write_enable writes
// mem_write_data (always zero) to mem_address on the same edge.
interface hough_peak_reader_if #(
  parameter int ADDR_W  = hough_pkg::ADDR_W,
  parameter int COUNT_W = hough_pkg::COUNT_W
);

  logic [ADDR_W-1:0]  mem_address;
  logic [COUNT_W-1:0] mem_read_data;
  logic               mem_write_enable;
  logic [COUNT_W-1:0] mem_write_data;
  logic               peak_valid;
  logic               peak_ready;
  logic [ADDR_W-1:0]  peak_rho;
  logic [COUNT_W-1:0] peak_votes;

  // Reader side.
  modport master (
    output mem_address, mem_write_enable, mem_write_data,
    output peak_valid, peak_rho, peak_votes,
    input  mem_read_data, peak_ready
  );

  // RAM model / consumer side.
  modport slave (
    input  mem_address, mem_write_enable, mem_write_data,
    input  peak_valid, peak_rho, peak_votes,
    output mem_read_data, peak_ready
  );

endinterface

// File: rtl/hough_peak_max.sv
// Registered running maximum over the scanned bins. A strictly-greater
// update means the first (lowest-address) bin wins a tie. clear reloads
// votes=0 and rho=-MAX_RHO, i.e. "bin 0 with no votes".
module hough_peak_max #(
  parameter int ADDR_W  = hough_pkg::ADDR_W,
  parameter int COUNT_W = hough_pkg::COUNT_W,
  parameter int MAX_RHO = hough_pkg::MAX_RHO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               update,
  input  logic [COUNT_W-1:0] vote,
  input  logic [ADDR_W-1:0]  rho,
  output logic [COUNT_W-1:0] max_votes,
  output logic [ADDR_W-1:0]  max_rho
);

  localparam logic [ADDR_W-1:0] RHO_FLOOR = ADDR_W'(-MAX_RHO);

  logic [COUNT_W-1:0] max_votes_q, max_votes_d;
  logic [ADDR_W-1:0]  max_rho_q, max_rho_d;

  // Next max: clear on scan start, strict-greater update while evaluating.
  always_comb begin
    max_votes_d = max_votes_q;
    max_rho_d   = max_rho_q;
    if (clear) begin
      max_votes_d = '0;
      max_rho_d   = RHO_FLOOR;
    end else if (update && (vote > max_votes_q)) begin
      max_votes_d = vote;
      max_rho_d   = rho;
    end
  end

  // Max registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      max_votes_q <= '0;
      max_rho_q   <= '0;
    end else begin
      max_votes_q <= max_votes_d;
      max_rho_q   <= max_rho_d;
    end
  end

  assign max_votes = max_votes_q;
  assign max_rho   = max_rho_q;

endmodule

// File: rtl/hough_peak_reader.sv
// Hough peak reader: after the voting FSM finishes a frame, walks the rho
// accumulator one bin at a time (ISSUE -> CAPTURE -> EVAL), streams every
// bin at or above THRESHOLD as a (rho, votes) candidate, and tracks the
// strongest bin.
// Build option HOUGH_PEAK_CLEAR_EN: when defined, each bin is written back
// to zero in its CAPTURE cycle so the accumulator is clean for the next
// frame; when undefined the accumulator is left untouched.
module hough_peak_reader
  import hough_pkg::*;
#(
  parameter int ADDR_W    = hough_pkg::ADDR_W,
  parameter int COUNT_W   = hough_pkg::COUNT_W,
  parameter int RHO_BINS  = hough_pkg::RHO_BINS,
  parameter int MAX_RHO   = hough_pkg::MAX_RHO,
  parameter int THRESHOLD = hough_pkg::THRESHOLD
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  hough_peak_reader_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   max_rho,
  output logic [COUNT_W-1:0]  max_votes,
  output rd_state_t           state_dbg
);

  localparam logic [ADDR_W-1:0]  LAST_BIN = ADDR_W'(RHO_BINS - 1);
  localparam logic [ADDR_W-1:0]  RHO_OFS  = ADDR_W'(MAX_RHO);
  localparam logic [COUNT_W-1:0] THRESH   = COUNT_W'(THRESHOLD);

  rd_state_t          state_q, state_d;
  logic [ADDR_W-1:0]  bin_q, bin_d;
  logic [COUNT_W-1:0] vote_q, vote_d;
  logic               we_q, we_d;
  logic               peak_valid_q, peak_valid_d;
  logic [ADDR_W-1:0]  peak_rho_q, peak_rho_d;
  logic [COUNT_W-1:0] peak_votes_q, peak_votes_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               advance;
  logic [ADDR_W-1:0]  bin_rho;
  logic               max_clear;
  logic               max_update;

  // Subtracting in ADDR_W bits gives the same low bits as widening to
  // ADDR_W+1 first, so bin_rho is the two's complement rho directly.
  assign bin_rho = bin_q - RHO_OFS;

  assign max_clear  = (state_q == RD_IDLE) && start;
  assign max_update = (state_q == RD_EVAL);

  // Scan sequencing: next state, bin pointer, candidate and strobe values.
  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    vote_d       = vote_q;
    we_d         = we_q;
    peak_valid_d = peak_valid_q;
    peak_rho_d   = peak_rho_q;
    peak_votes_d = peak_votes_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    advance      = 1'b0;

    case (state_q)
      RD_IDLE: begin
        if (start) begin
          state_d = RD_ISSUE;
          bin_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RD_ISSUE: begin
        state_d = RD_CAPTURE;
`ifdef HOUGH_PEAK_CLEAR_EN
        // The read of this bin was launched in ISSUE, so zeroing it during
        // CAPTURE cannot disturb the value being captured.
        we_d = 1'b1;
`endif
      end
      RD_CAPTURE: begin
        vote_d  = bus.mem_read_data;
        we_d    = 1'b0;
        state_d = RD_EVAL;
      end
      RD_EVAL: begin
        if (vote_q >= THRESH) begin
          state_d      = RD_EMIT;
          peak_valid_d = 1'b1;
          peak_rho_d   = bin_rho;
          peak_votes_d = vote_q;
        end else begin
          advance = 1'b1;
        end
      end
      RD_EMIT: begin
        if (bus.peak_ready) begin
          peak_valid_d = 1'b0;
          advance      = 1'b1;
        end
      end
      RD_FINISH: begin
        busy_d  = 1'b0;
        state_d = RD_IDLE;
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase

    if (advance) begin
      if (bin_q == LAST_BIN) begin
        state_d = RD_FINISH;
        done_d  = 1'b1;
      end else begin
        bin_d   = bin_q + ADDR_W'(1);
        state_d = RD_ISSUE;
      end
    end
  end

  // Reader state and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RD_IDLE;
      bin_q        <= '0;
      vote_q       <= '0;
      we_q         <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_rho_q   <= '0;
      peak_votes_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      vote_q       <= vote_d;
      we_q         <= we_d;
      peak_valid_q <= peak_valid_d;
      peak_rho_q   <= peak_rho_d;
      peak_votes_q <= peak_votes_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  hough_peak_max #(
    .ADDR_W  (ADDR_W),
    .COUNT_W (COUNT_W),
    .MAX_RHO (MAX_RHO)
  ) u_max (
    .clock     (clock),
    .reset     (reset),
    .clear     (max_clear),
    .update    (max_update),
    .vote      (vote_q),
    .rho       (bin_rho),
    .max_votes (max_votes),
    .max_rho   (max_rho)
  );

  assign bus.mem_address      = bin_q;
  assign bus.mem_write_enable = we_q;
  assign bus.mem_write_data   = '0;
  assign bus.peak_valid       = peak_valid_q;
  assign bus.peak_rho         = peak_rho_q;
  assign bus.peak_votes       = peak_votes_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign state_dbg            = state_q;

endmodule

// File: tb/tb_hough_peak_reader.sv
// Bench for hough_peak_reader: table of sparse-RAM scans with hand-computed
// candidates and maxima, plus stall, random-RAM and mid-scan reset sequences.
module tb_hough_peak_reader;
  import hough_pkg::*;

  localparam int AW = 11;
  localparam int CW = 16;
  localparam int NB = 1600;
  localparam int TH = 100;
  localparam int SCAN_CYCLES = 3 * NB;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  logic start;
  always #5 clock = ~clock;

  hough_peak_reader_if #(.ADDR_W(AW), .COUNT_W(CW)) bus ();

  logic          busy;
  logic          done;
  logic [AW-1:0] max_rho;
  logic [CW-1:0] max_votes;
  rd_state_t     state_dbg;

  hough_peak_reader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .max_rho   (max_rho),
    .max_votes (max_votes),
    .state_dbg (state_dbg)
  );

  // ---------------- accumulator RAM model ----------------
  logic [CW-1:0] ram      [2048];
  logic [CW-1:0] init_mem [2048];
  logic          load_req;

  always @(posedge clock) begin
    if (load_req) begin
      for (int i = 0; i < 2048; i++) ram[i] <= init_mem[i];
    end else if (bus.mem_write_enable) begin
      ram[bus.mem_address] <= bus.mem_write_data;
    end
    bus.mem_read_data <= ram[bus.mem_address];
  end

  // ---------------- candidate monitor ----------------
  logic [AW-1:0] got_rho   [2048];
  logic [CW-1:0] got_votes [2048];
  int            got_cnt;
  int            we_seen = 0;
  logic          clr_got;

  always @(negedge clock) begin
    if (bus.mem_write_enable === 1'b1) we_seen++;
    if (clr_got) begin
      got_cnt = 0;
    end else if (bus.peak_valid && bus.peak_ready) begin
      if (got_cnt < 2048) begin
        got_rho[got_cnt]   = bus.peak_rho;
        got_votes[got_cnt] = bus.peak_votes;
      end
      got_cnt++;
    end
  end

  // ---------------- scoreboard ----------------
  logic [AW+CW-1:0] exp_q[$];
  int n_cmp;
  int n_err;

  function automatic logic [AW-1:0] r(input int v);
    return AW'(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_image();
    for (int i = 0; i < 2048; i++) init_mem[i] = '0;
  endtask

  task automatic load_ram();
    load_req = 1'b1;
    clr_got  = 1'b1;
    tick();
    load_req = 1'b0;
    clr_got  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen; ends at a negedge.
  task automatic wait_done(input int budget, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clock);
      cycles++;
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mem"}, {bus.mem_address, bus.mem_write_enable, bus.mem_write_data}, 32'd0);
    check({tag, "_peak"}, {bus.peak_valid, bus.peak_rho, bus.peak_votes}, 32'd0);
    check({tag, "_status"}, {busy, done, max_rho, max_votes}, 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(RD_IDLE));
  endtask

  // Called at the negedge of the done cycle.
  task automatic check_done(input string tag, input logic [AW-1:0] er, input logic [CW-1:0] ev);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    check({tag, "_max_rho"}, 32'(max_rho), 32'(er));
    check({tag, "_max_votes"}, 32'(max_votes), 32'(ev));
    tick();
    check({tag, "_after_done"}, {busy, done, 24'(state_dbg)}, {2'b00, 24'(RD_IDLE)});
    check({tag, "_max_held"}, {max_rho, max_votes}, {er, ev});
  endtask

  task automatic compare_cands(input string tag);
    int bad;
    int n;
    bad = 0;
    n = (got_cnt < exp_q.size()) ? got_cnt : exp_q.size();
    check({tag, "_cand_count"}, 32'(got_cnt), 32'(exp_q.size()));
    for (int i = 0; i < n; i++)
      if ({got_rho[i], got_votes[i]} !== exp_q[i]) bad++;
    check({tag, "_cand_data"}, 32'(bad), 32'd0);
    exp_q.delete();
  endtask

  // Bins below zero_end are expected cleared in the clearing build.
  task automatic check_ram(input string tag, input int zero_end);
    int bad;
    bad = 0;
    for (int i = 0; i < NB; i++) begin
`ifdef HOUGH_PEAK_CLEAR_EN
      if (i < zero_end) begin
        if (ram[i] !== '0) bad++;
      end else if (ram[i] !== init_mem[i]) bad++;
`else
      if (ram[i] !== init_mem[i]) bad++;
`endif
    end
    check({tag, "_ram"}, 32'(bad), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            bin_a;
    logic [CW-1:0] val_a;
    int            bin_b;
    logic [CW-1:0] val_b;
    int            ncand;
    logic [AW-1:0] c0_rho;
    logic [CW-1:0] c0_votes;
    logic [AW-1:0] c1_rho;
    logic [CW-1:0] c1_votes;
    logic [AW-1:0] exp_max_rho;
    logic [CW-1:0] exp_max_votes;
  } vec_t;

  vec_t vecs[5];

  // ---------------- test sequence ----------------
  initial begin
    int cyc;
    int seen;
    int bad;
    int ncand;
    logic [CW-1:0] mv;
    logic [AW-1:0] mr;
    string tag;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    load_req = 1'b0;
    clr_got = 1'b1;
    bus.peak_ready = 1'b1;
    clear_image();

    vecs[0] = '{0,   16'd0,     1,    16'd0,   0, r(0),    16'd0,     r(0),   16'd0,   r(-800), 16'd0};
    vecs[1] = '{900, 16'd150,   100,  16'd120, 2, r(-700), 16'd120,   r(100), 16'd150, r(100),  16'd150};
    vecs[2] = '{300, 16'd200,   500,  16'd200, 2, r(-500), 16'd200,   r(-300),16'd200, r(-500), 16'd200};
    vecs[3] = '{1599,16'd99,    0,    16'd100, 1, r(-800), 16'd100,   r(0),   16'd0,   r(-800), 16'd100};
    vecs[4] = '{799, 16'hFFFF,  1598, 16'd100, 2, r(-1),   16'hFFFF,  r(798), 16'd100, r(-1),   16'hFFFF};

    tick();
    tick();
    check_reset("reset");
    reset = 1'b0;
    clr_got = 1'b0;
    tick();

    // Sparse-RAM scans with consumer always ready.
    for (int v = 0; v < 5; v++) begin
      tag = $sformatf("vec%0d", v);
      clear_image();
      init_mem[vecs[v].bin_a] = vecs[v].val_a;
      init_mem[vecs[v].bin_b] = vecs[v].val_b;
      load_ram();
      if (vecs[v].ncand >= 1) exp_q.push_back({vecs[v].c0_rho, vecs[v].c0_votes});
      if (vecs[v].ncand >= 2) exp_q.push_back({vecs[v].c1_rho, vecs[v].c1_votes});
      pulse_start();
      wait_done(SCAN_CYCLES + 100, cyc);
      check({tag, "_cycles"}, 32'(cyc), 32'(SCAN_CYCLES + vecs[v].ncand));
      check_done(tag, vecs[v].exp_max_rho, vecs[v].exp_max_votes);
      compare_cands(tag);
      check_ram(tag, NB);
    end

    // Back-pressure: candidate at bin 10 held for 10 cycles; stray start ignored.
    clear_image();
    init_mem[10] = 16'd300;
    load_ram();
    bus.peak_ready = 1'b0;
    exp_q.push_back({r(-790), 16'd300});
    pulse_start();
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      tick();
      seen = int'(bus.peak_valid);
    end
    check("stall_valid_seen", 32'(seen), 32'd1);
    check("stall_data", {bus.peak_rho, bus.peak_votes}, {r(-790), 16'd300});
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      tick();
      if (!bus.peak_valid || bus.peak_rho !== r(-790) || bus.peak_votes !== 16'd300 ||
          bus.mem_address !== 11'd10 || state_dbg !== RD_EMIT) bad++;
    end
    start = 1'b0;
    check("stall_hold", 32'(bad), 32'd0);
    bus.peak_ready = 1'b1;
    tick();
    check("stall_release", 32'(bus.peak_valid), 32'd0);
    wait_done(SCAN_CYCLES + 100, cyc);
    check_done("stall", r(-790), 16'd300);
    compare_cands("stall");

    // Random accumulator contents, expected candidates from a reference walk.
    clear_image();
    ncand = 0;
    mv = '0;
    mr = r(-800);
    for (int i = 0; i < NB; i++) begin
      init_mem[i] = CW'($urandom_range(0, 255));
      if (init_mem[i] >= CW'(TH)) begin
        exp_q.push_back({r(i - 800), init_mem[i]});
        ncand++;
      end
      if (init_mem[i] > mv) begin
        mv = init_mem[i];
        mr = r(i - 800);
      end
    end
    load_ram();
    pulse_start();
    wait_done(SCAN_CYCLES + NB + 100, cyc);
    check("rand_cycles", 32'(cyc), 32'(SCAN_CYCLES + ncand));
    check_done("rand", mr, mv);
    compare_cands("rand");
    check_ram("rand", NB);

    // Reset while the scan sits at bin 700 (below-threshold data only).
    clear_image();
    for (int i = 0; i < NB; i++) init_mem[i] = CW'($urandom_range(1, 99));
    load_ram();
    pulse_start();
    seen = 0;
    for (int i = 0; i < 3000 && seen == 0; i++) begin
      tick();
      seen = int'(bus.mem_address == 11'd700);
    end
    check("midscan_reached_700", 32'(seen), 32'd1);
    reset = 1'b1;
    tick();
    check_reset("midscan_reset");
    reset = 1'b0;
    tick();
    tick();
    check("midscan_stays_idle", {busy, 24'(state_dbg)}, {1'b0, 24'(RD_IDLE)});
    check_ram("midscan", 700);

`ifdef HOUGH_PEAK_CLEAR_EN
    check("clear_strobe_seen", 32'(we_seen != 0), 32'd1);
`else
    check("no_clear_strobe", 32'(we_seen), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hough_peak_reader.md
# hough_peak_reader

Read-side companion to the Hough voting FSM. Once the voting FSM reports a frame complete, this block scans the rho accumulator RAM bin by bin. Every bin whose vote count reaches a threshold is streamed out as a (rho, votes) candidate over a valid/ready handshake. At the end of the scan it reports the single strongest bin, and it can optionally zero the accumulator for the next frame.

## Interface
Parameters:
- ADDR_W, 11, accumulator address width (2048 locations)
- COUNT_W, 16, vote count width per bin
- RHO_BINS, 1600, number of bins scanned, addresses 0..RHO_BINS-1
- MAX_RHO, 800, address offset; rho = address − MAX_RHO
- THRESHOLD, 100, minimum votes for a candidate

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse, driven from the voting FSM's ready
- mem_address  out  ADDR_W  accumulator RAM address
- mem_read_data  in  COUNT_W  RAM read data, 1-cycle registered latency
- mem_write_enable  out  1  clear strobe (macro-dependent)
- mem_write_data  out  COUNT_W  always 0
- peak_valid  out  1  candidate available
- peak_ready  in  1  consumer accepts candidate
- peak_rho  out  ADDR_W  signed rho of candidate
- peak_votes  out  COUNT_W  votes of candidate
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at end of scan
- max_rho  out  ADDR_W  signed rho of strongest bin
- max_votes  out  COUNT_W  votes of strongest bin

## Operation
- States: IDLE, ISSUE, CAPTURE, EVAL, EMIT, FINISH.
- IDLE:
  - start=1 → ISSUE.
  - Clear bin counter, max_votes=0, max_rho=−MAX_RHO.
- ISSUE: drive mem_address=bin → CAPTURE.
- CAPTURE:
  - Register mem_read_data into vote register.
  - mem_address held at bin.
  - → EVAL.
- EVAL:
  - Max update: if vote > max_votes (strict), then max_votes=vote and max_rho=bin−MAX_RHO. Ties keep the lowest address.
  - If vote ≥ THRESHOLD → EMIT.
  - Otherwise, if bin=RHO_BINS−1 → FINISH, else bin+1 and → ISSUE.
- EMIT:
  - peak_valid=1 with peak_rho/peak_votes stable until peak_valid&&peak_ready.
  - After the handshake, apply the same last-bin/advance rule as EVAL.
- FINISH: done=1 for one cycle → IDLE.
- rho arithmetic: bin zero-extended to ADDR_W+1, minus MAX_RHO, truncated to ADDR_W two's complement. Range is −800..+799.
- start while not in IDLE: ignored.
- Reset mid-scan: → IDLE, every output to its reset value. Bins already cleared stay cleared; no resume.

## Timing
- Reset values:
  - mem_address=0, mem_write_enable=0, mem_write_data=0.
  - peak_valid=0, peak_rho=0, peak_votes=0.
  - busy=0, done=0, max_rho=0, max_votes=0.
- start sampled at edge N; busy=1 from cycle N+1 until done falls.
- Cost per bin: 3 cycles (ISSUE/CAPTURE/EVAL), plus EMIT cycles until the handshake. The EMIT minimum is 1 cycle if peak_ready is already high.
- Scan with no candidates: done at cycle N+1+3·RHO_BINS (4801 for defaults).
- max_rho/max_votes are valid in the done cycle and held until the next start.
- peak_valid never drops without a handshake except on reset.

## Configuration
- HOUGH_PEAK_CLEAR_EN defined:
  - In CAPTURE, mem_write_enable=1 at mem_address=bin with data 0.
  - The read is not disturbed, because the read data was registered from ISSUE.
  - Accumulator is all-zero after done.
- Undefined: mem_write_enable tied 0 and accumulator is left intact.

## Structure
- Shared package hough_pkg:
  - Constants MAX_RHO=800, RHO_BINS=1600, ADDR_W, COUNT_W.
  - Reader state encoding, one-hot.
  - The voting FSM uses the same MAX_RHO and bin constants.
- One natural sub-module, hough_peak_max: registered running-max comparator with strict-greater update and clear-on-start.

## Test plan
- Directed scenarios:
  - All-zero RAM, start pulse → no peak_valid; done at cycle N+4801; max_votes=0, max_rho=−800.
  - Bin 900=150, bin 100=120, others 0, peak_ready=1 → candidates (−700,120) then (100,150); max_rho=100, max_votes=150.
  - Bins 300 and 500 both 200 → max_rho=−500 (lowest address wins tie).
  - Bin 1599=99 and bin 0=100 → only (−800,100) emitted; threshold boundary inclusive.
  - peak_ready low for 10 cycles on a candidate → peak_valid and data held stable; scan stalls.
  - HOUGH_PEAK_CLEAR_EN defined, random RAM → all 1600 bins read back 0 after done. Reset asserted mid-scan at bin 700 → next cycle all outputs at reset values, state IDLE.
